// File: rtl/imem_loader_if.sv
// Byte-stream, imem write port and fetch-redirect signals of the boot-time
// instruction memory loader.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W:0]   word_count;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              halting;
    logic              taken;
    logic [ADDR_W-1:0] br_addr;
    logic              busy;
    logic              done;

    modport master (
        output start, word_count, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, halting, taken, br_addr, busy, done
    );

    modport slave (
        input  start, word_count, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, halting, taken, br_addr, busy, done
    );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: holds the CPU halted, assembles a
// little-endian byte stream into 32-bit words, writes them to consecutive
// word addresses from BOOT_ADDR, then redirects fetch to BOOT_ADDR.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int BOOT_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus
);

    typedef enum logic [2:0] {HALT, LOAD, DRAIN, BOOT, RUN} state_t;

    localparam logic [ADDR_W:0]   MAX_COUNT = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   IDX_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BOOT_ADDR);

    state_t            r_state;
    state_t            w_nextState;
    logic [1:0]        r_byteCnt;
    logic [ADDR_W:0]   r_wordIdx;
    logic [ADDR_W:0]   r_count;
    logic [23:0]       r_partial;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;

    logic [ADDR_W:0]   w_clampedCount;
    logic              w_startOk;
    logic              w_byteFire;
    logic              w_wordDone;
    logic              w_lastWord;
    logic [ADDR_W-1:0] w_waddrNext;
    logic              w_rxReady;
    logic              w_halting;
    logic              w_taken;
    logic              w_busy;

    assign w_clampedCount = (bus.word_count > MAX_COUNT) ? MAX_COUNT : bus.word_count;
    assign w_startOk      = bus.start && ((r_state == HALT) || (r_state == RUN));
    assign w_byteFire     = bus.rx_valid && w_rxReady;
    assign w_wordDone     = w_byteFire && (r_byteCnt == 2'd3);
    assign w_lastWord     = ((r_wordIdx + IDX_ONE) == r_count);
    assign w_waddrNext    = BASE + r_wordIdx[ADDR_W-1:0];

    // State register; reset drops straight back to HALT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HALT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; start is only honoured from HALT or RUN.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HALT, RUN: begin
                if (bus.start) begin
                    w_nextState = (w_clampedCount == '0) ? BOOT : LOAD;
                end
            end
            LOAD: begin
                if (w_wordDone && w_lastWord) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN:   w_nextState = BOOT;
            BOOT:    w_nextState = RUN;
            default: w_nextState = HALT;
        endcase
    end

    // Moore outputs toward the byte source and the fetch stage.
    always_comb begin
        w_rxReady = 1'b0;
        w_halting = 1'b1;
        w_taken   = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            HALT: begin
                w_halting = 1'b1;
            end
            LOAD: begin
                w_rxReady = 1'b1;
                w_busy    = 1'b1;
            end
            DRAIN: begin
                w_busy    = 1'b1;
            end
            BOOT: begin
                w_halting = 1'b0;
                w_taken   = 1'b1;
                w_busy    = 1'b1;
            end
            RUN: begin
                w_halting = 1'b0;
            end
            default: begin
                w_halting = 1'b1;
            end
        endcase
    end

    // Byte assembly and the registered imem write port; a new session clears the partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_byteCnt <= 2'd0;
            r_wordIdx <= '0;
            r_count   <= '0;
            r_partial <= 24'd0;
            r_we      <= 1'b0;
            r_waddr   <= BASE;
            r_wdata   <= 32'd0;
        end else begin
            r_we <= 1'b0;
            if (w_startOk) begin
                r_byteCnt <= 2'd0;
                r_wordIdx <= '0;
                r_count   <= w_clampedCount;
                r_partial <= 24'd0;
            end else if (w_byteFire) begin
                r_byteCnt <= r_byteCnt + 2'd1;
                case (r_byteCnt)
                    2'd0: r_partial[7:0]   <= bus.rx_data;
                    2'd1: r_partial[15:8]  <= bus.rx_data;
                    2'd2: r_partial[23:16] <= bus.rx_data;
                    default: begin
                        r_we      <= 1'b1;
                        r_waddr   <= w_waddrNext;
                        r_wdata   <= {bus.rx_data, r_partial};
                        r_wordIdx <= r_wordIdx + IDX_ONE;
                    end
                endcase
            end
        end
    end

    assign bus.rx_ready = w_rxReady;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.halting  = w_halting;
    assign bus.taken    = w_taken;
    assign bus.done     = w_taken;
    assign bus.busy     = w_busy;
    assign bus.br_addr  = BASE;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: one instance booting at 0 and one booting
// at 1022 to exercise address wrap.
module tb_imem_loader;

    localparam int ADDR_W = 10;

    logic clk = 1'b0;
    logic rst;

    int checks    = 0;
    int passed    = 0;
    int taken0    = 0;
    int overlaps  = 0;
    int takenMark = 0;

    logic [41:0] log0 [$];
    logic [41:0] log1 [$];

    logic [7:0] t1Bytes [8] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    logic [7:0] t4Bytes [6] = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h11, 8'h22};
    logic [7:0] t4Reload [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus0 ();
    imem_loader_if #(.ADDR_W(ADDR_W)) bus1 ();

    imem_loader #(.ADDR_W(ADDR_W), .BOOT_ADDR(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    imem_loader #(.ADDR_W(ADDR_W), .BOOT_ADDR(1022)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // Record every imem write and redirect, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus0.we) log0.push_back({bus0.waddr, bus0.wdata});
        if (bus1.we) log1.push_back({bus1.waddr, bus1.wdata});
        if (bus0.taken) taken0++;
        if (bus0.taken && bus0.halting) overlaps++;
        if (bus1.taken && bus1.halting) overlaps++;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic applyStimulus(input int sel, input logic st, input logic [ADDR_W:0] cnt,
                                 input logic vld, input logic [7:0] dat);
        if (sel == 0) begin
            bus0.start = st; bus0.word_count = cnt; bus0.rx_valid = vld; bus0.rx_data = dat;
        end else begin
            bus1.start = st; bus1.word_count = cnt; bus1.rx_valid = vld; bus1.rx_data = dat;
        end
    endtask

    function automatic logic [41:0] logEntry(input int sel, input int idx);
        if (sel == 0) return (idx < log0.size()) ? log0[idx] : '1;
        return (idx < log1.size()) ? log1[idx] : '1;
    endfunction

    task automatic waitTaken(input int sel, input string tag);
        int n = 0;
        logic t;
        t = (sel == 0) ? bus0.taken : bus1.taken;
        while (!t && n < 20) begin
            step();
            n++;
            t = (sel == 0) ? bus0.taken : bus1.taken;
        end
        checkBit(tag, t, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 1'b0, '0, 1'b0, 8'h00);
        applyStimulus(1, 1'b0, '0, 1'b0, 8'h00);
        #2;
        checkBit("rst_halting", bus0.halting, 1'b1);
        checkBit("rst_rx_ready", bus0.rx_ready, 1'b0);
        checkBit("rst_we", bus0.we, 1'b0);
        checkBit("rst_taken", bus0.taken, 1'b0);
        checkBit("rst_done", bus0.done, 1'b0);
        checkBit("rst_busy", bus0.busy, 1'b0);
        checkOutput("rst_waddr", 64'(bus0.waddr), 64'd0);
        checkOutput("rst_wdata", 64'(bus0.wdata), 64'd0);
        checkOutput("rst_br_addr", 64'(bus0.br_addr), 64'd0);
        checkOutput("rst_waddr_b1022", 64'(bus1.waddr), 64'd1022);
        step();
        step();
        rst = 1'b0;
        step();

        // Two words back-to-back.
        applyStimulus(0, 1'b1, 11'd2, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 11'd2, 1'b0, 8'h00);
        checkBit("t1_rx_ready", bus0.rx_ready, 1'b1);
        checkBit("t1_busy", bus0.busy, 1'b1);
        checkBit("t1_halting", bus0.halting, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 11'd2, 1'b1, t1Bytes[i]);
            step();
            if (i == 3) begin
                checkBit("t1_we0", bus0.we, 1'b1);
                checkOutput("t1_waddr0", 64'(bus0.waddr), 64'd0);
                checkOutput("t1_wdata0", 64'(bus0.wdata), 64'h12345678);
                checkBit("t1_still_load", bus0.rx_ready, 1'b1);
            end
        end
        applyStimulus(0, 1'b0, 11'd2, 1'b0, 8'h00);
        checkBit("t1_we1", bus0.we, 1'b1);
        checkOutput("t1_waddr1", 64'(bus0.waddr), 64'd1);
        checkOutput("t1_wdata1", 64'(bus0.wdata), 64'hDEADBEEF);
        checkBit("t1_drain_rx_ready", bus0.rx_ready, 1'b0);
        checkBit("t1_drain_halting", bus0.halting, 1'b1);
        step();
        checkBit("t1_boot_taken", bus0.taken, 1'b1);
        checkBit("t1_boot_done", bus0.done, 1'b1);
        checkBit("t1_boot_halting", bus0.halting, 1'b0);
        checkBit("t1_boot_busy", bus0.busy, 1'b1);
        checkBit("t1_boot_we", bus0.we, 1'b0);
        checkOutput("t1_br_addr", 64'(bus0.br_addr), 64'd0);
        step();
        checkBit("t1_run_taken", bus0.taken, 1'b0);
        checkBit("t1_run_busy", bus0.busy, 1'b0);
        checkBit("t1_run_halting", bus0.halting, 1'b0);
        checkOutput("t1_log_size", 64'(log0.size()), 64'd2);

        // Same load from RUN with a one-cycle gap after every byte.
        log0.delete();
        takenMark = taken0;
        applyStimulus(0, 1'b1, 11'd2, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 11'd2, 1'b0, 8'h00);
        checkBit("t2_halting_after_start", bus0.halting, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1'b0, 11'd2, 1'b1, t1Bytes[i]);
            step();
            applyStimulus(0, 1'b0, 11'd2, 1'b0, 8'hFF);
            if (i < 7) step();
        end
        step();
        waitTaken(0, "t2_taken");
        step();
        checkOutput("t2_log_size", 64'(log0.size()), 64'd2);
        checkOutput("t2_entry0", 64'(logEntry(0, 0)), 64'({10'd0, 32'h12345678}));
        checkOutput("t2_entry1", 64'(logEntry(0, 1)), 64'({10'd1, 32'hDEADBEEF}));
        checkOutput("t2_taken_cycles", 64'(taken0 - takenMark), 64'd1);

        // Zero-count start from HALT.
        rst = 1'b1;
        step();
        rst = 1'b0;
        log0.delete();
        takenMark = taken0;
        applyStimulus(0, 1'b1, 11'd0, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 11'd0, 1'b0, 8'h00);
        checkBit("t3_taken", bus0.taken, 1'b1);
        checkBit("t3_done", bus0.done, 1'b1);
        checkBit("t3_halting", bus0.halting, 1'b0);
        checkBit("t3_we", bus0.we, 1'b0);
        step();
        checkBit("t3_taken_off", bus0.taken, 1'b0);
        checkOutput("t3_taken_cycles", 64'(taken0 - takenMark), 64'd1);
        checkOutput("t3_no_writes", 64'(log0.size()), 64'd0);

        // Reset after six bytes of a three-word load, then reload.
        log0.delete();
        applyStimulus(0, 1'b1, 11'd3, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'b0, 11'd3, 1'b1, t4Bytes[i]);
            step();
        end
        applyStimulus(0, 1'b0, 11'd3, 1'b0, 8'h00);
        rst = 1'b1;
        #1;
        checkBit("t4_rst_halting", bus0.halting, 1'b1);
        checkBit("t4_rst_rx_ready", bus0.rx_ready, 1'b0);
        checkBit("t4_rst_we", bus0.we, 1'b0);
        checkBit("t4_rst_busy", bus0.busy, 1'b0);
        step();
        rst = 1'b0;
        checkOutput("t4_log_size", 64'(log0.size()), 64'd1);
        checkOutput("t4_entry0", 64'(logEntry(0, 0)), 64'({10'd0, 32'h12345678}));
        applyStimulus(0, 1'b1, 11'd1, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1'b0, 11'd1, 1'b1, t4Reload[i]);
            step();
        end
        applyStimulus(0, 1'b0, 11'd1, 1'b0, 8'h00);
        checkOutput("t4_reload_waddr", 64'(bus0.waddr), 64'd0);
        checkOutput("t4_reload_wdata", 64'(bus0.wdata), 64'hDDCCBBAA);
        step();
        checkBit("t4_reload_taken", bus0.taken, 1'b1);
        step();

        // Start pulsed during LOAD must not disturb the session.
        log0.delete();
        applyStimulus(0, 1'b1, 11'd2, 1'b0, 8'h00);
        step();
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(0, 1'b0, 11'd2, 1'b1, 8'(i));
            step();
        end
        applyStimulus(0, 1'b1, 11'd0, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 11'd0, 1'b0, 8'h00);
        checkBit("t6_load_ignores_start", bus0.rx_ready, 1'b1);
        checkBit("t6_no_taken", bus0.taken, 1'b0);
        for (int i = 3; i <= 8; i++) begin
            applyStimulus(0, 1'b0, 11'd0, 1'b1, 8'(i));
            step();
        end
        applyStimulus(0, 1'b0, 11'd0, 1'b0, 8'h00);
        waitTaken(0, "t6_taken");
        step();
        checkOutput("t6_log_size", 64'(log0.size()), 64'd2);
        checkOutput("t6_entry0", 64'(logEntry(0, 0)), 64'({10'd0, 32'h04030201}));
        checkOutput("t6_entry1", 64'(logEntry(0, 1)), 64'({10'd1, 32'h08070605}));

        // rx_valid in RUN is not consumed.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b0, 11'd1, 1'b1, 8'h99);
            checkBit("t6_run_rx_ready", bus0.rx_ready, 1'b0);
            step();
        end
        checkOutput("t6_run_no_writes", 64'(log0.size()), 64'd2);
        applyStimulus(0, 1'b1, 11'd1, 1'b0, 8'h00);
        step();
        applyStimulus(0, 1'b0, 11'd1, 1'b0, 8'h00);
        checkBit("t6_restart_halting", bus0.halting, 1'b1);
        checkBit("t6_restart_rx_ready", bus0.rx_ready, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(0, 1'b0, 11'd1, 1'b1, 8'(i * 17));
            step();
        end
        applyStimulus(0, 1'b0, 11'd1, 1'b0, 8'h00);
        checkOutput("t6_restart_waddr", 64'(bus0.waddr), 64'd0);
        checkOutput("t6_restart_wdata", 64'(bus0.wdata), 64'h44332211);
        step();
        step();

        // Address wrap with BOOT_ADDR = 1022.
        log1.delete();
        applyStimulus(1, 1'b1, 11'd4, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 1'b0, 11'd4, 1'b1, 8'(i));
            step();
        end
        applyStimulus(1, 1'b0, 11'd4, 1'b0, 8'h00);
        waitTaken(1, "t5_taken");
        checkOutput("t5_br_addr", 64'(bus1.br_addr), 64'd1022);
        step();
        checkOutput("t5_log_size", 64'(log1.size()), 64'd4);
        checkOutput("t5_entry0", 64'(logEntry(1, 0)), 64'({10'd1022, 32'h03020100}));
        checkOutput("t5_entry1", 64'(logEntry(1, 1)), 64'({10'd1023, 32'h07060504}));
        checkOutput("t5_entry2", 64'(logEntry(1, 2)), 64'({10'd0, 32'h0B0A0908}));
        checkOutput("t5_entry3", 64'(logEntry(1, 3)), 64'({10'd1, 32'h0F0E0D0C}));

        checkOutput("halting_taken_overlap", 64'(overlaps), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
